// File: rtl/mux_scan_ctrl_if.sv
// Bundle of the scan controller's data/handshake signals.
// The slave modport is the controller's view; the master modport is the
// view of whatever drives requests, returns mux data and consumes results.
interface mux_scan_ctrl_if;
  logic       enable;     // permit new scans to start
  logic [7:0] req;        // per-channel data-pending flags
  logic [7:0] mux_out;    // data from the external 8:1 mux for current sel
  logic       out_ready;  // consumer accepts out_data when out_valid is high
  logic [2:0] sel;        // channel select to the external mux
  logic [7:0] out_data;   // captured channel data
  logic [2:0] out_ch;     // channel index of out_data
  logic       out_valid;  // out_data/out_ch are valid
  logic [7:0] ack;        // one-hot, one-cycle capture pulse
  logic       busy;       // controller is not idle

  modport master (
    output enable, req, mux_out, out_ready,
    input  sel, out_data, out_ch, out_valid, ack, busy
  );

  modport slave (
    input  enable, req, mux_out, out_ready,
    output sel, out_data, out_ch, out_valid, ack, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller for an external 8:1 multiplexer.
// Picks the next pending channel after the last granted one, drives sel,
// waits SETTLE+1 cycles for the mux path to settle, captures mux_out and
// presents it on a valid/ready output with a one-cycle one-hot ack pulse.
// SETTLE is meaningful over 1..15 (4-bit settle counter).
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;    // last granted channel
  logic [3:0] cnt_q,   cnt_d;    // settle countdown
  logic [2:0] sel_q,   sel_d;
  logic [7:0] data_q,  data_d;
  logic [2:0] ch_q,    ch_d;
  logic       valid_q, valid_d;
  logic [7:0] ack_q,   ack_d;
  logic       busy_q,  busy_d;

  logic [2:0] pick;       // first pending channel after ptr, wrapping
  logic       pick_vld;   // at least one channel pending

  // Round-robin search starting one past the last granted channel.
  // The eighth probe lands on ptr itself, so a lone request is re-granted.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!pick_vld && bus.req[3'(int'(ptr_q) + k)]) begin
        pick     = 3'(int'(ptr_q) + k);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> SETTLE -> HOLD scan.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ack_d   = 8'h00;   // ack only ever lasts the cycle after a capture

    case (state_q)
      ST_IDLE: begin
        // enable and req are only consulted here; once a scan starts it
        // runs to completion regardless of them.
        if (bus.enable && pick_vld) begin
          sel_d   = pick;
          cnt_d   = SETTLE_CNT;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // The counter is loaded with SETTLE and captured when found at 0,
        // so out_valid rises SETTLE+1 edges after the granting edge.
        if (cnt_q == 4'd0) begin
          data_d  = bus.mux_out;
          ch_d    = sel_q;
          valid_d = 1'b1;
          ack_d   = 8'h01 << sel_q;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_HOLD: begin
        // Outputs are frozen until the consumer takes them. Returning to
        // IDLE first guarantees a gap cycle before the next grant.
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          ptr_d   = ch_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset clears everything and primes ptr
  // to 7 so channel 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd7;
      cnt_q   <= 4'd0;
      sel_q   <= 3'd0;
      data_q  <= 8'h00;
      ch_q    <= 3'd0;
      valid_q <= 1'b0;
      ack_q   <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a cycle table for the basic
// SETTLE=1 handshake, then hand-written sequences for round-robin order,
// wrap-around, stalls, aborted scans and reset mid-transaction (SETTLE=3).
module tb_mux_scan_ctrl;

  logic clk;
  logic reset1;
  logic reset3;

  logic [7:0] mux_base1;
  logic [7:0] mux_base3;

  int n_tests;
  int n_fail;

  mux_scan_ctrl_if if1 ();
  mux_scan_ctrl_if if3 ();

  // External mux model: each channel returns base + channel index.
  assign if1.mux_out = mux_base1 + {5'd0, if1.sel};
  assign if3.mux_out = mux_base3 + {5'd0, if3.sel};

  mux_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (if1)
  );

  mux_scan_ctrl #(.SETTLE(3)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic [2:0] e_sel;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_ch;
    logic [7:0] e_ack;
    logic       e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on dut1 with out_ready already high: wait (bounded) for
  // out_valid, check the captured channel/data, then the accept edge.
  task automatic run_txn(input logic [2:0] exp_ch, input string tag);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if1.out_valid) break;
    end
    check({tag, ".valid"}, if1.out_valid, 1'b1);
    check({tag, ".ch"},    if1.out_ch, exp_ch);
    check({tag, ".data"},  if1.out_data, mux_base1 + {5'd0, exp_ch});
    check({tag, ".ack"},   if1.ack, 8'h01 << exp_ch);
    tick();
    check({tag, ".gap_busy"},  if1.busy, 1'b0);
    check({tag, ".gap_valid"}, if1.out_valid, 1'b0);
  endtask

  task automatic check_zero1(input string tag);
    check({tag, ".sel"},   if1.sel, 3'd0);
    check({tag, ".data"},  if1.out_data, 8'h00);
    check({tag, ".ch"},    if1.out_ch, 3'd0);
    check({tag, ".valid"}, if1.out_valid, 1'b0);
    check({tag, ".ack"},   if1.ack, 8'h00);
    check({tag, ".busy"},  if1.busy, 1'b0);
  endtask

  task automatic check_zero3(input string tag);
    check({tag, ".sel"},   if3.sel, 3'd0);
    check({tag, ".data"},  if3.out_data, 8'h00);
    check({tag, ".ch"},    if3.out_ch, 3'd0);
    check({tag, ".valid"}, if3.out_valid, 1'b0);
    check({tag, ".ack"},   if3.ack, 8'h00);
    check({tag, ".busy"},  if3.busy, 1'b0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Basic SETTLE=1 handshake; after the edge following each row's inputs.
    //           en    req    rdy   sel   vld   data   ch    ack    busy
    vecs[0]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1}; // grant ch0
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1}; // settling
    vecs[2]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'hA5, 3'd0, 8'h01, 1'b1}; // capture
    vecs[3]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0}; // accept
    vecs[4]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1}; // re-grant ch0
    vecs[5]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 8'hA5, 3'd0, 8'h01, 1'b1}; // capture
    vecs[7]  = '{1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 8'hA5, 3'd0, 8'h00, 1'b1}; // stalled
    vecs[8]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0}; // accept
    vecs[9]  = '{1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0}; // disabled
    vecs[10] = '{1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0};

    reset1 = 1'b1;
    reset3 = 1'b1;
    mux_base1 = 8'hA5;
    mux_base3 = 8'h5A;
    if1.enable = 1'b0; if1.req = 8'h00; if1.out_ready = 1'b0;
    if3.enable = 1'b0; if3.req = 8'h00; if3.out_ready = 1'b0;

    tick();
    check_zero1("rst1");
    check_zero3("rst3");
    reset1 = 1'b0;
    reset3 = 1'b0;
    tick();
    check_zero1("post_rst1");

    // ---- table-driven basic handshake ----
    for (int i = 0; i < 11; i++) begin
      if1.enable    = vecs[i].en;
      if1.req       = vecs[i].req;
      if1.out_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d.sel", i),   if1.sel,       vecs[i].e_sel);
      check($sformatf("vec%0d.valid", i), if1.out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d.ack", i),   if1.ack,       vecs[i].e_ack);
      check($sformatf("vec%0d.busy", i),  if1.busy,      vecs[i].e_busy);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d.data", i), if1.out_data, vecs[i].e_data);
        check($sformatf("vec%0d.ch", i),   if1.out_ch,   vecs[i].e_ch);
      end
    end

    // ---- reset restores ptr=7: req=FF grants 0..7,0 ----
    reset1 = 1'b1;
    #1;
    check_zero1("rst1b");
    tick();
    reset1 = 1'b0;
    mux_base1 = 8'h00;
    if1.req = 8'hFF;
    if1.out_ready = 1'b1;
    if1.enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      run_txn(3'(c), $sformatf("rr%0d", c));
    end
    if1.enable = 1'b0;

    // ---- wrap-around: grant ch4, then req=90 gives 7,4,7 ----
    if1.req = 8'h10;
    if1.enable = 1'b1;
    run_txn(3'd4, "wrap_ch4");
    if1.req = 8'h90;
    run_txn(3'd7, "wrap_a");
    run_txn(3'd4, "wrap_b");
    run_txn(3'd7, "wrap_c");
    if1.enable = 1'b0;
    if1.req = 8'h00;
    tick();

    // ---- HOLD stall for 10 cycles while mux_out moves (ptr=7 -> ch1) ----
    mux_base1 = 8'h30;
    if1.out_ready = 1'b0;
    if1.req = 8'h02;
    if1.enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if1.out_valid) break;
    end
    check("stall.valid0", if1.out_valid, 1'b1);
    check("stall.ch",     if1.out_ch, 3'd1);
    check("stall.data0",  if1.out_data, 8'h31);
    check("stall.ack0",   if1.ack, 8'h02);
    if1.enable = 1'b0;
    if1.req = 8'h00;
    for (int k = 0; k < 10; k++) begin
      mux_base1 = 8'h40 + 8'(k);
      tick();
      check($sformatf("stall%0d.valid", k), if1.out_valid, 1'b1);
      check($sformatf("stall%0d.data", k),  if1.out_data, 8'h31);
      check($sformatf("stall%0d.ack", k),   if1.ack, 8'h00);
    end
    if1.out_ready = 1'b1;
    tick();
    check("stall.accept_valid", if1.out_valid, 1'b0);
    check("stall.accept_busy",  if1.busy, 1'b0);

    // ---- req/enable dropped during SETTLE: capture still happens ----
    mux_base1 = 8'h10;
    if1.req = 8'h08;
    if1.enable = 1'b1;
    tick();
    check("drop.grant_sel",  if1.sel, 3'd3);
    check("drop.grant_busy", if1.busy, 1'b1);
    if1.req = 8'h00;
    if1.enable = 1'b0;
    tick();
    check("drop.settle_valid", if1.out_valid, 1'b0);
    tick();
    check("drop.cap_valid", if1.out_valid, 1'b1);
    check("drop.cap_ch",    if1.out_ch, 3'd3);
    check("drop.cap_data",  if1.out_data, 8'h13);
    check("drop.cap_ack",   if1.ack, 8'h08);
    tick();
    check("drop.accept_busy", if1.busy, 1'b0);
    if1.req = 8'hFF;
    tick();
    tick();
    check("idle.disabled_busy", if1.busy, 1'b0);
    check("idle.disabled_sel",  if1.sel, 3'd3);

    // ---- SETTLE=3: reset in SETTLE, then latency of 4 edges ----
    if3.req = 8'h01;
    if3.out_ready = 1'b1;
    if3.enable = 1'b1;
    tick();
    check("s3.grant_busy", if3.busy, 1'b1);
    tick();
    check("s3.settle_busy", if3.busy, 1'b1);
    reset3 = 1'b1;
    #1;
    check_zero3("s3.rst_async");
    tick();
    check_zero3("s3.rst_hold_a");
    tick();
    check_zero3("s3.rst_hold_b");
    reset3 = 1'b0;
    tick();
    check("s3.e0_busy",  if3.busy, 1'b1);
    check("s3.e0_sel",   if3.sel, 3'd0);
    check("s3.e0_valid", if3.out_valid, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("s3.e%0d_valid", e), if3.out_valid, 1'b0);
      check($sformatf("s3.e%0d_ack", e),   if3.ack, 8'h00);
    end
    tick();
    check("s3.e4_valid", if3.out_valid, 1'b1);
    check("s3.e4_ch",    if3.out_ch, 3'd0);
    check("s3.e4_data",  if3.out_data, 8'h5A);
    check("s3.e4_ack",   if3.ack, 8'h01);
    if3.enable = 1'b0;
    tick();
    check("s3.accept_valid", if3.out_valid, 1'b0);
    check("s3.accept_ack",   if3.ack, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
